// File: rtl/branch_resolve_bht.sv
// Execute-stage branch/jump resolution with a bimodal BHT, registered flush/redirect and squash window.
// Optional BRANCH_STATS_EN adds stat_branches / stat_mispredicts counters.
module branch_resolve_bht #(
   parameter int unsigned XLEN          = 32,
   parameter int unsigned BHT_ENTRIES   = 64,
   parameter int unsigned CTR_BITS      = 2,
   parameter int unsigned SQUASH_CYCLES = 1
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [XLEN-1:0] if_pc,
   output logic            if_pred_taken,
   input  logic            is_valid,
   input  logic            is_stall,
   input  logic [6:0]      is_opcode,
   input  logic [2:0]      is_func3,
   input  logic [XLEN-1:0] is_pc,
   input  logic [XLEN-1:0] is_rs1_data,
   input  logic [XLEN-1:0] is_rs2_data,
   input  logic [XLEN-1:0] i_imm,
   input  logic            is_pred_taken,
   output logic            branch_flush,
   output logic [XLEN-1:0] branch_pc,
   output logic            misalign_exc
`ifdef BRANCH_STATS_EN
  ,output logic [31:0]     stat_branches,
   output logic [31:0]     stat_mispredicts
`endif
);

   localparam int unsigned IDX  = $clog2(BHT_ENTRIES);
   localparam int unsigned SQ_W = $clog2(SQUASH_CYCLES + 1);
   localparam logic [CTR_BITS-1:0] CTR_WEAK_NT = CTR_BITS'((1 << (CTR_BITS - 1)) - 1);
   localparam logic [CTR_BITS-1:0] CTR_MAX     = '1;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;

   typedef enum logic {ST_RUN, ST_SQUASH} state_e;

   state_e              state_q, state_d;
   logic [SQ_W-1:0]     sq_cnt_q, sq_cnt_d;
   logic [CTR_BITS-1:0] bht_q [BHT_ENTRIES];
   logic [CTR_BITS-1:0] bht_d [BHT_ENTRIES];
   logic                branch_flush_q, branch_flush_d;
   logic [XLEN-1:0]     branch_pc_q, branch_pc_d;
   logic                misalign_exc_q, misalign_exc_d;

   logic            accept, is_cond, is_jump, is_jalr, cond_taken, actual_taken;
   logic            recognised, mispredict, do_flush, do_misalign;
   logic [XLEN-1:0] sum_pc, sum_rs1, target, fall_through;
   logic [IDX-1:0]  look_idx, upd_idx;
   logic            unused_if_pc;

   assign look_idx      = if_pc[IDX+1:2];
   assign upd_idx       = is_pc[IDX+1:2];
   assign unused_if_pc  = ^if_pc;
   assign if_pred_taken = bht_q[look_idx][CTR_BITS-1];

   assign accept = is_valid & ~is_stall & (state_q == ST_RUN);

   always_comb begin
      is_cond    = 1'b0;
      is_jump    = 1'b0;
      cond_taken = 1'b0;
      case (is_opcode)
         OP_BRANCH: begin
            is_cond = 1'b1;
            case (is_func3)
               3'b000:  cond_taken = (is_rs1_data == is_rs2_data);
               3'b001:  cond_taken = (is_rs1_data != is_rs2_data);
               3'b100:  cond_taken = ($signed(is_rs1_data) <  $signed(is_rs2_data));
               3'b101:  cond_taken = ($signed(is_rs1_data) >= $signed(is_rs2_data));
               3'b110:  cond_taken = (is_rs1_data <  is_rs2_data);
               3'b111:  cond_taken = (is_rs1_data >= is_rs2_data);
               default: is_cond    = 1'b0;
            endcase
         end
         OP_JAL, OP_JALR: is_jump = 1'b1;
         default: ;
      endcase
   end

   assign is_jalr      = (is_opcode == OP_JALR);
   assign recognised   = is_cond | is_jump;
   assign actual_taken = is_jump | cond_taken;
   assign sum_pc       = is_pc + i_imm;
   assign sum_rs1      = is_rs1_data + i_imm;
   assign target       = is_jalr ? (sum_rs1 & {{(XLEN-1){1'b1}}, 1'b0}) : sum_pc;
   assign fall_through = is_pc + XLEN'(4);

   // JALR always redirects: fetch never knows its register-based target.
   assign mispredict  = is_jalr | (actual_taken != is_pred_taken);
   assign do_misalign = accept & recognised & actual_taken & target[1];
   assign do_flush    = accept & recognised & mispredict & ~do_misalign;

   always_comb begin
      branch_flush_d = do_flush;
      misalign_exc_d = do_misalign;
      branch_pc_d    = '0;
      if (do_flush || do_misalign) begin
         branch_pc_d = actual_taken ? target : fall_through;
      end
   end

   always_comb begin
      state_d  = state_q;
      sq_cnt_d = sq_cnt_q;
      case (state_q)
         ST_RUN: begin
            if (do_flush) begin
               state_d  = ST_SQUASH;
               sq_cnt_d = SQ_W'(SQUASH_CYCLES);
            end
         end
         ST_SQUASH: begin
            if (sq_cnt_q <= SQ_W'(1)) begin
               state_d  = ST_RUN;
               sq_cnt_d = '0;
            end else begin
               sq_cnt_d = sq_cnt_q - 1'b1;
            end
         end
         default: begin
            state_d  = ST_RUN;
            sq_cnt_d = '0;
         end
      endcase
   end

   always_comb begin
      bht_d = bht_q;
      if (accept && is_cond) begin
         if (cond_taken) begin
            if (bht_q[upd_idx] != CTR_MAX) bht_d[upd_idx] = bht_q[upd_idx] + 1'b1;
         end else begin
            if (bht_q[upd_idx] != '0) bht_d[upd_idx] = bht_q[upd_idx] - 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q        <= ST_RUN;
         sq_cnt_q       <= '0;
         branch_flush_q <= 1'b0;
         branch_pc_q    <= '0;
         misalign_exc_q <= 1'b0;
         for (int unsigned i = 0; i < BHT_ENTRIES; i++) bht_q[i] <= CTR_WEAK_NT;
      end else begin
         state_q        <= state_d;
         sq_cnt_q       <= sq_cnt_d;
         branch_flush_q <= branch_flush_d;
         branch_pc_q    <= branch_pc_d;
         misalign_exc_q <= misalign_exc_d;
         bht_q          <= bht_d;
      end
   end

   assign branch_flush = branch_flush_q;
   assign branch_pc    = branch_pc_q;
   assign misalign_exc = misalign_exc_q;

`ifdef BRANCH_STATS_EN
   logic [31:0] stat_branches_q, stat_branches_d;
   logic [31:0] stat_mispredicts_q, stat_mispredicts_d;

   always_comb begin
      stat_branches_d    = stat_branches_q + {31'd0, accept & recognised};
      stat_mispredicts_d = stat_mispredicts_q + {31'd0, do_flush};
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         stat_branches_q    <= '0;
         stat_mispredicts_q <= '0;
      end else begin
         stat_branches_q    <= stat_branches_d;
         stat_mispredicts_q <= stat_mispredicts_d;
      end
   end

   assign stat_branches    = stat_branches_q;
   assign stat_mispredicts = stat_mispredicts_q;
`endif

endmodule
